dma_bus_arbiter: RTL and testbench
==================================

Name: dma_bus_arbiter

Overview:
- Owns 68030 bus-mastership negotiation for the DMA engine: requests the bus (BR_), waits for grant (BG_), takes ownership once the bus is quiet (BGACK_), and issues per-cycle start strobes to the CPU-side state machine.
- Counts completed cycles per tenure and releases the bus at a burst limit, on end of data or on DMA disable.
- Sits between FIFO/DMA control logic and the CPU_SM bus-cycle sequencer.

Parameters:
MAX_BURST, 8, bus cycles permitted per tenure before mandatory release (1..255)
GRANT_TIMEOUT, 255, SCLK cycles BR_ may stay asserted without grant before backoff (2..1023)
BACKOFF, 4, SCLK cycles BR_ is negated after a timeout before re-request (1..15)

Ports:
SCLK  in  1  system clock
_RST  in  1  reset; asynchronous, active-low
DMAENA  in  1  DMA enabled; level
XFER_REQ  in  1  FIFO logic requests data movement; level
BG_  in  1  68030 bus grant, asynchronous, active-low
AS_I_  in  1  bus address strobe (any master), asynchronous, active-low
BGACK_I_  in  1  external bus-grant-ack from other masters, asynchronous, active-low
CYCLEDONE  in  1  one-SCLK pulse from CPU_SM: current bus cycle finished
BR_  out  1  bus request to 68030, active-low
BGACK_O_  out  1  our bus-grant-ack, active-low
BGACK_OE  out  1  output enable for BGACK_O_ driver
CYCLE_START  out  1  one-SCLK pulse: CPU_SM may begin a bus cycle
BUS_OWNED  out  1  high while this block holds the bus
ARB_TO  out  1  one-SCLK pulse on grant timeout
BURST_CNT  out  8  cycles completed in current tenure

Behaviour:
- Reset (async, _RST low): state IDLE; BR_=1, BGACK_O_=1, BGACK_OE=0, CYCLE_START=0, BUS_OWNED=0, ARB_TO=0, BURST_CNT=0, all counters 0, synchroniser flops 1. Reset mid-tenure immediately releases BGACK_ and BR_.
- BG_, AS_I_, BGACK_I_ pass through 2-flop synchronisers (reset value 1); all decisions use synchronised versions (2-cycle latency). CYCLEDONE, DMAENA, XFER_REQ are synchronous.
- All outputs registered.
- States:
  IDLE: if DMAENA & XFER_REQ -> REQ (BR_=0 next cycle).
  REQ: BR_=0; timeout counter increments. If ~DMAENA -> IDLE (BR_=1). If sync BG_=0 -> WAITFREE. If counter reaches GRANT_TIMEOUT-1 with no grant -> BACKOFF, ARB_TO pulses once.
  BACKOFF: BR_=1 for BACKOFF cycles, then -> REQ if DMAENA & XFER_REQ, else IDLE.
  WAITFREE: BR_ held 0; wait sync AS_I_=1 and BGACK_I_=1 in the same cycle -> OWN. If BG_ is withdrawn (returns 1) before that -> REQ (timeout counter cleared).
  OWN: BGACK_OE=1, BGACK_O_=0, BR_=1, BUS_OWNED=1; CYCLE_START pulses on state entry -> CYCLE.
  CYCLE: wait CYCLEDONE. On CYCLEDONE, BURST_CNT+1. Then: if BURST_CNT+1==MAX_BURST, or ~XFER_REQ, or ~DMAENA -> RELEASE; else CYCLE_START pulses the next cycle and stay in CYCLE.
  RELEASE: BGACK_O_=1 driven high for one cycle (OE still 1), BUS_OWNED=0; then -> IDLE with BGACK_OE=0; BURST_CNT cleared on IDLE entry.
- A cycle in flight is never abandoned: DMAENA drop in CYCLE takes effect only at CYCLEDONE.
- Only one CYCLE_START per CYCLEDONE. CYCLEDONE outside CYCLE is ignored.
- BURST_CNT saturates at MAX_BURST; never wraps.
- A request re-asserted during RELEASE is served only after passing through IDLE (minimum one IDLE cycle between tenures).

Decomposition:
- Shared package dma_arb_pkg: state encoding constants (IDLE, REQ, BACKOFF, WAITFREE, OWN, CYCLE, RELEASE, 3-bit), default parameter values.
- One sub-module, bus_sync2: 2-flop synchroniser with async active-low reset to 1, instanced ×3.

Test Plan:
- Grant path: XFER_REQ=1, BG_ low 3 cycles after BR_, bus idle -> BR_ falls 1 cycle after request; BGACK_O_=0 2 cycles after BG_ sync; CYCLE_START pulses once.
- Burst limit: MAX_BURST=4, XFER_REQ held, CYCLEDONE every 5 cycles -> exactly 4 CYCLE_STARTs; BURST_CNT reaches 4; RELEASE; BGACK_OE=0; BR_ re-asserted after 1 IDLE cycle.
- Timeout: GRANT_TIMEOUT=16, BG_ never asserted -> ARB_TO pulse after 16 cycles of BR_=0; BR_ high for BACKOFF=4 cycles; then BR_=0 again.
- Busy bus: BG_=0 while AS_I_=0 for 10 cycles -> BGACK_O_ stays 1 until 2 cycles after AS_I_ rises; BG_ withdrawn meanwhile -> back to REQ.
- DMAENA drop: drop in CYCLE before CYCLEDONE -> no further CYCLE_START; release after CYCLEDONE. Drop in REQ -> BR_=1 the next cycle, no BGACK_.
- Reset mid-tenure: _RST low in CYCLE -> BR_=1, BGACK_O_=1, BGACK_OE=0, BURST_CNT=0 asynchronously, before the next SCLK edge.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// Shared definitions for the DMA bus arbiter: state encoding and default
// tuning values for burst length, grant timeout and backoff.
package dma_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_BACKOFF  = 3'd2,
    ST_WAITFREE = 3'd3,
    ST_OWN      = 3'd4,
    ST_CYCLE    = 3'd5,
    ST_RELEASE  = 3'd6
  } arb_state_t;

  localparam int DEF_MAX_BURST     = 8;
  localparam int DEF_GRANT_TIMEOUT = 255;
  localparam int DEF_BACKOFF       = 4;

endpackage

// File: rtl/bus_sync2.sv
// Two-flop synchroniser for asynchronous active-low bus strobes; resets to
// the negated (high) level so nothing looks asserted out of reset.
module bus_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// 68030 bus-mastership negotiation for the DMA engine: BR_/BG_/BGACK_
// handshake, grant timeout with backoff, and per-cycle start strobes.
module dma_bus_arbiter
  import dma_arb_pkg::*;
#(
  parameter int MAX_BURST     = DEF_MAX_BURST,
  parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
  parameter int BACKOFF       = DEF_BACKOFF
) (
  input  logic       SCLK,
  input  logic       _RST,
  input  logic       DMAENA,
  input  logic       XFER_REQ,
  input  logic       BG_,
  input  logic       AS_I_,
  input  logic       BGACK_I_,
  input  logic       CYCLEDONE,
  output logic       BR_,
  output logic       BGACK_O_,
  output logic       BGACK_OE,
  output logic       CYCLE_START,
  output logic       BUS_OWNED,
  output logic       ARB_TO,
  output logic [7:0] BURST_CNT
);

  localparam logic [9:0] TO_LAST   = 10'(GRANT_TIMEOUT - 1);
  localparam logic [3:0] BO_LAST   = 4'(BACKOFF - 1);
  localparam logic [8:0] BURST_LIM = 9'(MAX_BURST);

  arb_state_t state, next_state;
  logic       bg_s, as_s, bgack_s;
  logic [9:0] to_cnt;
  logic [3:0] bo_cnt;
  logic [7:0] burst_cnt;
  logic [8:0] burst_inc;
  logic       to_hit, cont_cycle;
  logic       br_q, bgack_o_q, bgack_oe_q, cycle_start_q, bus_owned_q, arb_to_q;

  bus_sync2 u_sync_bg    (.clk(SCLK), .rst_n(_RST), .d(BG_),      .q(bg_s));
  bus_sync2 u_sync_as    (.clk(SCLK), .rst_n(_RST), .d(AS_I_),    .q(as_s));
  bus_sync2 u_sync_bgack (.clk(SCLK), .rst_n(_RST), .d(BGACK_I_), .q(bgack_s));

  assign burst_inc = {1'b0, burst_cnt} + 9'd1;

  always_comb begin
    next_state = state;
    to_hit     = 1'b0;
    cont_cycle = 1'b0;
    case (state)
      ST_IDLE:
        if (DMAENA && XFER_REQ) next_state = ST_REQ;
      ST_REQ:
        if (!DMAENA) next_state = ST_IDLE;
        else if (!bg_s) next_state = ST_WAITFREE;
        else if (to_cnt == TO_LAST) begin
          next_state = ST_BACKOFF;
          to_hit     = 1'b1;
        end
      ST_BACKOFF:
        if (bo_cnt == BO_LAST) next_state = (DMAENA && XFER_REQ) ? ST_REQ : ST_IDLE;
      // A withdrawn grant wins over a bus that just went quiet.
      ST_WAITFREE:
        if (bg_s) next_state = ST_REQ;
        else if (as_s && bgack_s) next_state = ST_OWN;
      ST_OWN:
        next_state = ST_CYCLE;
      // The cycle in flight always completes; exit decisions wait for CYCLEDONE.
      ST_CYCLE:
        if (CYCLEDONE) begin
          if (burst_inc >= BURST_LIM || !XFER_REQ || !DMAENA) next_state = ST_RELEASE;
          else cont_cycle = 1'b1;
        end
      ST_RELEASE:
        next_state = ST_IDLE;
      default:
        next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they change with the state.
  always_ff @(posedge SCLK or negedge _RST) begin
    if (!_RST) begin
      state         <= ST_IDLE;
      to_cnt        <= '0;
      bo_cnt        <= '0;
      burst_cnt     <= '0;
      br_q          <= 1'b1;
      bgack_o_q     <= 1'b1;
      bgack_oe_q    <= 1'b0;
      cycle_start_q <= 1'b0;
      bus_owned_q   <= 1'b0;
      arb_to_q      <= 1'b0;
    end else begin
      state         <= next_state;
      to_cnt        <= (state == ST_REQ && next_state == ST_REQ) ? to_cnt + 10'd1 : '0;
      bo_cnt        <= (state == ST_BACKOFF && next_state == ST_BACKOFF) ? bo_cnt + 4'd1 : '0;
      if (next_state == ST_IDLE)
        burst_cnt <= '0;
      else if (state == ST_CYCLE && CYCLEDONE)
        burst_cnt <= (burst_inc > BURST_LIM) ? BURST_LIM[7:0] : burst_inc[7:0];
      br_q          <= !(next_state inside {ST_REQ, ST_WAITFREE});
      bgack_o_q     <= !(next_state inside {ST_OWN, ST_CYCLE});
      bgack_oe_q    <= next_state inside {ST_OWN, ST_CYCLE, ST_RELEASE};
      bus_owned_q   <= next_state inside {ST_OWN, ST_CYCLE};
      cycle_start_q <= (next_state == ST_OWN) || cont_cycle;
      arb_to_q      <= to_hit;
    end
  end

  assign BR_         = br_q;
  assign BGACK_O_    = bgack_o_q;
  assign BGACK_OE    = bgack_oe_q;
  assign CYCLE_START = cycle_start_q;
  assign BUS_OWNED   = bus_owned_q;
  assign ARB_TO      = arb_to_q;
  assign BURST_CNT   = burst_cnt;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: a cycle-by-cycle vector table for
// grant/burst/release, then directed sequences for timeout, busy bus and reset.
module tb_dma_bus_arbiter;

  logic       sclk = 1'b0;
  logic       rst_n;
  logic       dmaena, xfer_req, bg_n, as_n, bgack_i_n, cycledone;
  logic       br_n, bgack_o_n, bgack_oe, cycle_start, bus_owned, arb_to;
  logic [7:0] burst_cnt;

  int total = 0;
  int bad   = 0;

  // stim = {DMAENA, XFER_REQ, BG_, AS_I_, BGACK_I_, CYCLEDONE}
  // outs = {BR_, BGACK_O_, BGACK_OE, CYCLE_START, BUS_OWNED, ARB_TO}
  typedef struct {
    logic [5:0] stim;
    logic [5:0] outs;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  dma_bus_arbiter #(.MAX_BURST(4), .GRANT_TIMEOUT(16), .BACKOFF(4)) dut (
    .SCLK(sclk), ._RST(rst_n), .DMAENA(dmaena), .XFER_REQ(xfer_req),
    .BG_(bg_n), .AS_I_(as_n), .BGACK_I_(bgack_i_n), .CYCLEDONE(cycledone),
    .BR_(br_n), .BGACK_O_(bgack_o_n), .BGACK_OE(bgack_oe),
    .CYCLE_START(cycle_start), .BUS_OWNED(bus_owned), .ARB_TO(arb_to),
    .BURST_CNT(burst_cnt)
  );

  always #5 sclk = ~sclk;

  function automatic vec_t mk(input logic [5:0] s, input logic [5:0] o, input logic [7:0] c);
    vec_t v;
    v.stim = s;
    v.outs = o;
    v.cnt  = c;
    return v;
  endfunction

  function automatic logic [13:0] outVec();
    return {br_n, bgack_o_n, bgack_oe, cycle_start, bus_owned, arb_to, burst_cnt};
  endfunction

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] s);
    {dmaena, xfer_req, bg_n, as_n, bgack_i_n, cycledone} = s;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  initial begin
    int low, hi, seen, lat, ok, cs_seen;

    // Grant with BG_ low from row 4, bursts of 4 with CYCLEDONE every other
    // cycle, release, one IDLE cycle, re-request, DMAENA drop in REQ.
    vecs.push_back(mk(6'b101110, 6'b110000, 8'd0));
    vecs.push_back(mk(6'b111110, 6'b010000, 8'd0));
    vecs.push_back(mk(6'b111110, 6'b010000, 8'd0));
    vecs.push_back(mk(6'b111110, 6'b010000, 8'd0));
    vecs.push_back(mk(6'b110110, 6'b010000, 8'd0));
    vecs.push_back(mk(6'b110110, 6'b010000, 8'd0));
    vecs.push_back(mk(6'b110110, 6'b010000, 8'd0));
    vecs.push_back(mk(6'b110110, 6'b101110, 8'd0));
    vecs.push_back(mk(6'b111110, 6'b101010, 8'd0));
    vecs.push_back(mk(6'b111111, 6'b101110, 8'd1));
    vecs.push_back(mk(6'b111110, 6'b101010, 8'd1));
    vecs.push_back(mk(6'b111111, 6'b101110, 8'd2));
    vecs.push_back(mk(6'b111110, 6'b101010, 8'd2));
    vecs.push_back(mk(6'b111111, 6'b101110, 8'd3));
    vecs.push_back(mk(6'b111110, 6'b101010, 8'd3));
    vecs.push_back(mk(6'b111111, 6'b111000, 8'd4));
    vecs.push_back(mk(6'b111110, 6'b110000, 8'd0));
    vecs.push_back(mk(6'b111110, 6'b010000, 8'd0));
    vecs.push_back(mk(6'b011110, 6'b110000, 8'd0));
    vecs.push_back(mk(6'b001111, 6'b110000, 8'd0));

    rst_n = 1'b1;
    applyStimulus(6'b001110);
    #2 rst_n = 1'b0;
    #1 checkOutput("reset_state", 32'(outVec()), 32'({6'b110000, 8'd0}));
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].stim);
      tick();
      checkOutput($sformatf("vec%0d", i), 32'(outVec()), 32'({vecs[i].outs, vecs[i].cnt}));
    end

    // Grant timeout: 16 cycles of BR_ low, one ARB_TO pulse, 4 cycles of backoff.
    applyStimulus(6'b111110);
    low = 0; seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (arb_to) begin
        seen = 1;
        break;
      end
      if (!br_n) low++;
    end
    checkOutput("timeout_seen", 32'(seen), 32'd1);
    checkOutput("timeout_br_low_cycles", 32'(low), 32'd16);
    checkOutput("timeout_br_released", 32'(br_n), 32'd1);
    tick();
    checkOutput("timeout_single_pulse", 32'(arb_to), 32'd0);
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      if (!br_n) break;
      hi++;
      tick();
    end
    checkOutput("backoff_cycles", 32'(hi), 32'd4);
    checkOutput("rerequest_br", 32'(br_n), 32'd0);
    dmaena = 1'b0;
    tick();
    tick();

    // Busy bus: grant present but AS_I_ low, so no BGACK_ until it rises.
    applyStimulus(6'b110010);
    tick();
    tick();
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bgack_o_n && !br_n) ok++;
    end
    checkOutput("busy_bus_hold", 32'(ok), 32'd10);
    as_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      lat++;
      if (!bgack_o_n) break;
    end
    checkOutput("as_rise_latency", 32'(lat), 32'd3);
    checkOutput("own_start_pulse", 32'({cycle_start, bgack_oe, bus_owned}), 32'b111);

    // DMAENA drop mid-cycle: no new start, bus held until CYCLEDONE.
    dmaena = 1'b0;
    cs_seen = 0; ok = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cycle_start) cs_seen++;
      if (!bgack_o_n) ok++;
    end
    checkOutput("dmaena_drop_no_start", 32'(cs_seen), 32'd0);
    checkOutput("dmaena_drop_held", 32'(ok), 32'd3);
    cycledone = 1'b1;
    tick();
    cycledone = 1'b0;
    checkOutput("dmaena_drop_release", 32'(outVec()), 32'({6'b111000, 8'd1}));
    tick();
    checkOutput("dmaena_drop_idle", 32'(outVec()), 32'({6'b110000, 8'd0}));

    // Grant withdrawn while bus busy: back to REQ, quiet bus alone is not enough.
    applyStimulus(6'b110010);
    for (int i = 0; i < 4; i++) tick();
    bg_n = 1'b1;
    ok = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bgack_o_n && !br_n) ok++;
    end
    as_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bgack_o_n && !br_n) ok++;
    end
    checkOutput("withdrawn_grant_no_ack", 32'(ok), 32'd7);
    bg_n = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      lat++;
      if (!bgack_o_n) break;
    end
    checkOutput("regrant_latency", 32'(lat), 32'd4);
    tick();
    cycledone = 1'b1;
    tick();
    cycledone = 1'b0;
    checkOutput("second_cycle_start", 32'({cycle_start, burst_cnt}), 32'({1'b1, 8'd1}));
    tick();

    // Asynchronous reset mid-tenure, checked before the next clock edge.
    #3 rst_n = 1'b0;
    #1 checkOutput("reset_mid_tenure", 32'({br_n, bgack_o_n, bgack_oe, burst_cnt}), 32'({3'b110, 8'd0}));
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
